// File: rtl/battery_gauge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : battery_gauge
// Brief    : Coulomb-counting battery gauge with debounced charger detect.
//            Optional low-battery alarm enabled by macro GAUGE_LOW_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module battery_gauge #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int UNITS_PER_PCT   = 100,
    parameter int INIT_LEVEL      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        charger_raw,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        sample_dir,
    input  logic [11:0] sample_current,
    output logic        charger_plugged,
    output logic [7:0]  battery_level,
    output logic        level_valid,
    output logic        full,
    output logic        sat_err,
    output logic        low_battery
);

    localparam int                 c_INIT_INT   = (INIT_LEVEL > 100) ? 100 : INIT_LEVEL;
    localparam logic [7:0]         c_INIT_LEVEL = 8'(c_INIT_INT);
    localparam logic [7:0]         c_LEVEL_MAX  = 8'd100;
    localparam logic [7:0]         c_DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0]        c_CUR_MAX    = 12'(UNITS_PER_PCT - 1);
    localparam logic signed [13:0] c_UNITS      = 14'(UNITS_PER_PCT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_NORM  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_run;
    logic               r_sync1;
    logic               r_sync2;
    logic [7:0]         r_db_cnt;
    logic               r_plugged;
    logic [7:0]         r_level;
    logic signed [13:0] r_frac;
    logic [11:0]        r_cur;
    logic               r_dir;
    logic               r_discard;
    logic               r_level_valid;
    logic               r_sat;

    logic               w_accept;
    logic               w_clamp;
    logic               w_discard;
    logic [11:0]        w_cur;
    logic signed [13:0] w_cur_ext;
    logic signed [13:0] w_frac_norm;
    logic [7:0]         w_level_norm;

    assign sample_ready    = r_run && (r_state == ST_IDLE);
    assign w_accept        = sample_valid && sample_ready;
    assign w_clamp         = (sample_current > c_CUR_MAX);
    assign w_cur           = w_clamp ? c_CUR_MAX : sample_current;
    assign w_discard       = sample_dir && (!r_plugged || (r_level == c_LEVEL_MAX));
    assign w_cur_ext       = signed'({2'b00, r_cur});
    assign charger_plugged = r_plugged;
    assign battery_level   = r_level;
    assign level_valid     = r_level_valid;
    assign full            = (r_level == c_LEVEL_MAX);
    assign sat_err         = r_sat;

    // Charger presence: two-flop synchroniser followed by a restartable debounce count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_cnt  <= '0;
            r_plugged <= 1'b0;
        end else begin
            r_sync1 <= charger_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_plugged) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_plugged <= ~r_plugged;
                    r_db_cnt  <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 8'd1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_APPLY;
            ST_APPLY: w_next_state = ST_NORM;
            ST_NORM:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // One carry/borrow step; an empty battery absorbs the borrow, a full one drops the fraction.
    always_comb begin
        w_frac_norm  = r_frac;
        w_level_norm = r_level;
        if (r_frac >= c_UNITS) begin
            w_frac_norm  = r_frac - c_UNITS;
            w_level_norm = r_level + 8'd1;
        end else if (r_frac < 14'sd0) begin
            if (r_level == 8'd0) begin
                w_frac_norm = '0;
            end else begin
                w_frac_norm  = r_frac + c_UNITS;
                w_level_norm = r_level - 8'd1;
            end
        end
        if (w_level_norm == c_LEVEL_MAX) w_frac_norm = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level       <= c_INIT_LEVEL;
            r_frac        <= '0;
            r_cur         <= '0;
            r_dir         <= 1'b0;
            r_discard     <= 1'b0;
            r_level_valid <= 1'b0;
            r_sat         <= 1'b0;
        end else begin
            r_level_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cur     <= w_cur;
                        r_dir     <= sample_dir;
                        r_discard <= w_discard;
                        if (w_clamp && !w_discard) r_sat <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    if (!r_discard) r_frac <= r_dir ? (r_frac + w_cur_ext) : (r_frac - w_cur_ext);
                end
                ST_NORM: begin
                    r_frac        <= w_frac_norm;
                    r_level       <= w_level_norm;
                    r_level_valid <= (w_level_norm != r_level);
                end
                default: ;
            endcase
        end
    end

`ifdef GAUGE_LOW_ALARM_EN
    logic r_low;

    // Hysteresis band 16..19 holds the previous alarm state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_low <= 1'b0;
        end else if (r_level <= 8'd15) begin
            r_low <= 1'b1;
        end else if (r_level >= 8'd20) begin
            r_low <= 1'b0;
        end
    end

    assign low_battery = r_low;
`else
    assign low_battery = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_battery_gauge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_battery_gauge
// Brief    : Scoreboard bench for battery_gauge against a total-charge model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_battery_gauge;

    localparam int U = 100;
`ifdef GAUGE_LOW_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        charger_raw = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_dir = 1'b0;
    logic [11:0] sample_current = '0;
    logic        sample_ready;
    logic        charger_plugged;
    logic [7:0]  battery_level;
    logic        level_valid;
    logic        full;
    logic        sat_err;
    logic        low_battery;

    battery_gauge dut (
        .clk             (clk),
        .reset           (reset),
        .charger_raw     (charger_raw),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .sample_dir      (sample_dir),
        .sample_current  (sample_current),
        .charger_plugged (charger_plugged),
        .battery_level   (battery_level),
        .level_valid     (level_valid),
        .full            (full),
        .sat_err         (sat_err),
        .low_battery     (low_battery)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] level;
        logic       lv;
        logic       full;
        logic       sat;
        logic       low;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   pending = 0;
    int   checks  = 0;
    int   passes  = 0;
    int   cyc     = 0;

    // Model state: total charge in units, so level = q / U and frac = q % U.
    int   m_q;
    bit   m_sat;
    bit   m_low;
    bit   m_plugged;

    always @(posedge clk) cyc = cyc + 1;

    function automatic bit hyst(input int lvl, input bit cur);
        if (!ALARM_EN) return 1'b0;
        if (lvl <= 15) return 1'b1;
        if (lvl >= 20) return 1'b0;
        return cur;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q       = 0;
        m_sat     = 1'b0;
        m_plugged = 1'b0;
        m_low     = hyst(0, 1'b0);
    endtask

    task automatic send(input bit dir, input int cur);
        exp_t e;
        int   prev;
        int   eff;
        bit   ok;
        ok = 1'b0;
        @(negedge clk);
        sample_valid   = 1'b1;
        sample_dir     = dir;
        sample_current = 12'(cur);
        for (int i = 0; i < 20; i++) begin
            if (sample_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'(sample_ready), 32'd1);
            sample_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        prev  = m_q / U;
        e.low = m_low;
        eff   = (cur > U - 1) ? U - 1 : cur;
        if (dir) begin
            if (m_plugged && prev < 100) begin
                if (cur > U - 1) m_sat = 1'b1;
                m_q = m_q + eff;
                if (m_q >= 100 * U) m_q = 100 * U;
            end
        end else begin
            if (cur > U - 1) m_sat = 1'b1;
            m_q = m_q - eff;
            if (m_q < 0) m_q = 0;
        end
        e.level = 8'(m_q / U);
        e.lv    = ((m_q / U) != prev);
        e.full  = ((m_q / U) == 100);
        e.sat   = m_sat;
        m_low   = hyst(m_q / U, m_low);
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        pending++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && pending > 0; i++) @(negedge clk);
        if (pending > 0) check("drain_timeout", 32'(pending), 32'd0);
    endtask

    task automatic drive_to(input int lvl);
        for (int i = 0; i < 400 && (m_q / U) < lvl; i++) send(1'b1, $urandom_range(1, 99));
        for (int i = 0; i < 400 && (m_q / U) > lvl; i++) send(1'b0, $urandom_range(1, 99));
        if ((m_q % U) != 0) send(1'b0, m_q % U);
    endtask

    task automatic set_charger(input bit v);
        wait_idle();
        @(negedge clk);
        charger_raw = v;
        repeat (25) @(negedge clk);
        m_plugged = v;
    endtask

    exp_t mon_e;
    int   mon_a;

    // Monitor: a sample completes when the block becomes ready again.
    always @(negedge clk) begin
        if (reset && pending > 0 && sample_ready) begin
            mon_e = exp_q.pop_front();
            mon_a = acc_q.pop_front();
            pending--;
            check("sample_result{level,lv,full,sat,low}",
                  32'({battery_level, level_valid, full, sat_err, low_battery}), 32'(mon_e));
            check("result_latency", 32'(cyc - mon_a), 32'd2);
        end else if (reset && level_valid) begin
            check("spurious_level_valid", 32'(level_valid), 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rise_at;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(sample_ready), 32'd0);
        check("reset_outputs{plug,level,lv,sat,low}",
              32'({charger_plugged, battery_level, level_valid, sat_err, low_battery}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(sample_ready), 32'd1);

        // Charge while unplugged is discarded.
        send(1'b1, 50);

        // Debounce: short rise, 5-cycle drop, then a stable final edge.
        @(posedge clk); #1; charger_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1; charger_raw = 1'b0;
        repeat (5) @(posedge clk);
        check("plugged_during_glitch", 32'(charger_plugged), 32'd0);
        #1; charger_raw = 1'b1;
        rise_at = -1;
        for (int n = 1; n <= 40 && rise_at < 0; n++) begin
            @(posedge clk); #1;
            if (charger_plugged) rise_at = n;
        end
        check("debounce_rise_cycles", 32'(rise_at), 32'd18);
        m_plugged = 1'b1;

        // Borrow at zero, then saturation.
        send(1'b0, 30);
        send(1'b0, 4000);

        // Carry: 50 + 60 + 50 units -> 51 with frac 10.
        drive_to(50);
        send(1'b1, 60);
        send(1'b1, 50);
        send(1'b0, 10);
        send(1'b0, 1);

        // Full clamp.
        drive_to(100);
        send(1'b1, 99);
        send(1'b0, 1);
        send(1'b1, 1);

        // Alarm band.
        drive_to(16);
        send(1'b0, 1);
        drive_to(19);
        drive_to(20);
        drive_to(14);

        // Randomised traffic with one unplug/replug.
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)), $urandom_range(0, 120));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (i == 15) set_charger(1'b0);
            if (i == 25) set_charger(1'b1);
        end
        wait_idle();

        // Reset while the FSM is in NORM.
        @(negedge clk);
        sample_valid   = 1'b1;
        sample_dir     = 1'b0;
        sample_current = 12'd5;
        @(posedge clk); #1; sample_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        #1;
        check("midnorm_reset_ready", 32'(sample_ready), 32'd0);
        check("midnorm_reset_outputs{plug,level,lv,sat,low}",
              32'({charger_plugged, battery_level, level_valid, sat_err, low_battery}), 32'd0);
        exp_q.delete();
        acc_q.delete();
        pending = 0;
        model_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("ready_after_midnorm_reset", 32'(sample_ready), 32'd1);
        send(1'b0, 7);
        wait_idle();
        repeat (25) @(negedge clk);
        m_plugged = 1'b1;
        send(1'b1, 99);
        send(1'b1, 5);
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
